// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// FSM state encoding, default sizing and Booth recoding pair codes.
package mult_div_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    // FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Booth pair {multiplier[0], q-1}: 00/11 no-op, 01 add, 10 subtract
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/mult_div_unit_signed_div_core.sv
// Restoring division datapath on operand magnitudes with sign fix-up.
// load_i captures magnitudes and result signs; each step_i cycle retires one
// quotient bit. quot_o/rem_o present the signed result of the step being
// taken this cycle, so the caller can register them on the last step edge.
module signed_div_core #(
    parameter int WIDTH = mult_div_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             q_neg_q, r_neg_q;

    // Magnitudes are formed in WIDTH+1 bits so the most negative operand
    // produces 2^(WIDTH-1) rather than wrapping back to itself.
    logic [WIDTH:0] dvd_ext, dvs_ext, dvd_mag, dvs_mag;
    logic           mag_unused;

    assign dvd_ext    = {dividend_i[WIDTH-1], dividend_i};
    assign dvs_ext    = {divisor_i[WIDTH-1],  divisor_i};
    assign dvd_mag    = dividend_i[WIDTH-1] ? (~dvd_ext + 1'b1) : dvd_ext;
    assign dvs_mag    = divisor_i[WIDTH-1]  ? (~dvs_ext + 1'b1) : dvs_ext;
    assign mag_unused = dvd_mag[WIDTH] ^ dvs_mag[WIDTH];

    // One restoring step: shift in the next dividend bit, subtract if it fits
    logic [WIDTH:0]   shifted, diff;
    logic             fits;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic             diff_unused;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = (shifted >= {1'b0, dvs_q});
        rem_d   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], fits};
    end

    assign diff_unused = diff[WIDTH];

    // Quotient negated when signs differ; remainder follows the dividend
    assign quot_o = q_neg_q ? (~quo_d + 1'b1) : quo_d;
    assign rem_o  = r_neg_q ? (~rem_d + 1'b1) : rem_d;

    // Operand capture and per-cycle remainder/quotient shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (load_i) begin
            rem_q   <= '0;
            quo_q   <= dvd_mag[WIDTH-1:0];
            dvs_q   <= dvs_mag[WIDTH-1:0];
            q_neg_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
            r_neg_q <= dividend_i[WIDTH-1];
        end else if (step_i) begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// Optional build macro MULT_DIV_EARLY_EXIT_EN: zero operands finish in one
// cycle; without it every non-zero-divisor operation takes WIDTH iterations.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] mult_hi,
    output logic [WIDTH-1:0] mult_lo,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_iter;

    // Booth register {acc, multiplier, q-1}; acc and multiplicand carry one
    // extra sign bit so subtracting -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]   acc_q, mcand_q, acc_d, booth_sum;
    logic [WIDTH-1:0] mpl_q, mpl_d;
    logic             q1_q;
    logic [1:0]       booth_pair;

    logic [WIDTH-1:0] mult_hi_q, mult_lo_q, div_hi_q, div_lo_q;
    logic             busy_q, done_q, div_zero_q;

    logic             div_load, div_step;
    logic [WIDTH-1:0] core_quot, core_rem;

    assign last_iter  = (cnt_q == CNT_W'(WIDTH - 1));
    assign booth_pair = {mpl_q[0], q1_q};

    // Booth step: add/sub multiplicand per pair code, then arithmetic shift
    always_comb begin
        booth_sum = acc_q;
        if (booth_pair == BOOTH_ADD)
            booth_sum = acc_q + mcand_q;
        else if (booth_pair == BOOTH_SUB)
            booth_sum = acc_q - mcand_q;
        acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mpl_d = {booth_sum[0], mpl_q[WIDTH-1:1]};
    end

    // A divide is only loaded when it actually starts (mult has priority)
    assign div_load = (state_q == ST_IDLE) && !start_mult && start_div
                      && (b_in != '0);
    assign div_step = (state_q == ST_DIV);

    signed_div_core #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (a_in),
        .divisor_i  (b_in),
        .quot_o     (core_quot),
        .rem_o      (core_rem)
    );

    // Control FSM, Booth iteration and registered result/status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mpl_q      <= '0;
            q1_q       <= 1'b0;
            mult_hi_q  <= '0;
            mult_lo_q  <= '0;
            div_hi_q   <= '0;
            div_lo_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (start_mult) begin
                        acc_q   <= '0;
                        mcand_q <= {a_in[WIDTH-1], a_in};
                        mpl_q   <= b_in;
                        q1_q    <= 1'b0;
`ifdef MULT_DIV_EARLY_EXIT_EN
                        if (a_in == '0 || b_in == '0) begin
                            state_q   <= ST_FIN;
                            done_q    <= 1'b1;
                            mult_hi_q <= '0;
                            mult_lo_q <= '0;
                        end else begin
                            state_q <= ST_MULT;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= ST_MULT;
                        busy_q  <= 1'b1;
`endif
                    end else if (start_div) begin
                        if (b_in == '0) begin
                            // Results are left as they were; only flag it
                            state_q    <= ST_FIN;
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
`ifdef MULT_DIV_EARLY_EXIT_EN
                        end else if (a_in == '0) begin
                            state_q  <= ST_FIN;
                            done_q   <= 1'b1;
                            div_hi_q <= '0;
                            div_lo_q <= '0;
`endif
                        end else begin
                            state_q <= ST_DIV;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_MULT: begin
                    acc_q <= acc_d;
                    mpl_q <= mpl_d;
                    q1_q  <= mpl_q[0];
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_q   <= ST_FIN;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        mult_hi_q <= acc_d[WIDTH-1:0];
                        mult_lo_q <= mpl_d;
                    end
                end
                ST_DIV: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_q  <= ST_FIN;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        div_hi_q <= core_rem;
                        div_lo_q <= core_quot;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mult_hi  = mult_hi_q;
    assign mult_lo  = mult_lo_q;
    assign div_hi   = div_hi_q;
    assign div_lo   = div_lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a result scoreboard.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start_mult = 1'b0;
    logic         start_div = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] mult_hi, mult_lo, div_hi, div_lo;
    logic         busy, done, div_zero;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a_in       (a_in),
        .b_in       (b_in),
        .mult_hi    (mult_hi),
        .mult_lo    (mult_lo),
        .div_hi     (div_hi),
        .div_lo     (div_lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic         zf;
        logic [W-1:0] mhi, mlo, dhi, dlo;
        int           lat;
    } exp_t;

    exp_t sb[$];

    int npass = 0;
    int nfail = 0;
    int ntotal = 0;

    // Model of the held result registers
    logic [W-1:0] m_mhi = '0, m_mlo = '0, m_dhi = '0, m_dlo = '0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint p, q, r;
        e.tag = tag;
        e.zf  = 1'b0;
        e.lat = W + 1;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            m_mhi = p[63:32];
            m_mlo = p[31:0];
        end else if (b == '0) begin
            e.zf  = 1'b1;
            e.lat = 1;
        end else begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            m_dlo = q[31:0];
            m_dhi = r[31:0];
        end
        e.mhi = m_mhi;
        e.mlo = m_mlo;
        e.dhi = m_dhi;
        e.dlo = m_dlo;
        sb.push_back(e);
    endtask

    // Drive one request (called #1 after a rising edge), wait for done with a
    // cycle bound, then compare against the scoreboard entry.
    task automatic run_op(input string tag, input bit sm, input bit sd,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int pulse_at);
        int   n = 0;
        int   busy_cnt = 0;
        int   done_cnt = 0;
        bit   got = 0;
        exp_t e;
        start_mult = sm;
        start_div  = sd;
        a_in = a;
        b_in = b;
        push_exp(tag, sm, a, b);
        while (n < 100 && !got) begin
            @(posedge clk); #1;
            n++;
            start_mult = 1'b0;
            start_div  = (n == pulse_at);
            if (done) begin
                got = 1;
                done_cnt++;
            end else if (busy) begin
                busy_cnt++;
            end
        end
        start_div = 1'b0;
        e = sb.pop_front();
        check({e.tag, "/done_seen"}, W'(got), W'(1));
        check({e.tag, "/latency"}, W'(n), W'(e.lat));
        check({e.tag, "/busy_cycles"}, W'(busy_cnt), W'(e.lat - 1));
        check({e.tag, "/busy_at_done"}, W'(busy), W'(0));
        check({e.tag, "/div_zero"}, W'(div_zero), W'(e.zf));
        check({e.tag, "/mult_hi"}, mult_hi, e.mhi);
        check({e.tag, "/mult_lo"}, mult_lo, e.mlo);
        check({e.tag, "/div_hi"}, div_hi, e.dhi);
        check({e.tag, "/div_lo"}, div_lo, e.dlo);
        // done is a single-cycle pulse and nothing restarts afterwards
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check({e.tag, "/done_pulses"}, W'(done_cnt), W'(1));
        check({e.tag, "/idle_busy"}, W'(busy), W'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/mult_hi"}, mult_hi, '0);
        check({tag, "/mult_lo"}, mult_lo, '0);
        check({tag, "/div_hi"}, div_hi, '0);
        check({tag, "/div_lo"}, div_lo, '0);
        check({tag, "/busy"}, W'(busy), '0);
        check({tag, "/done"}, W'(done), '0);
        check({tag, "/div_zero"}, W'(div_zero), '0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // 7 * -3
        run_op("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 0);
        check("mul_7_m3/hi_const", mult_hi, 32'hFFFF_FFFF);
        check("mul_7_m3/lo_const", mult_lo, 32'hFFFF_FFEB);

        // -7 / 2
        run_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_m7_2/quot_const", div_lo, 32'hFFFF_FFFD);
        check("div_m7_2/rem_const", div_hi, 32'hFFFF_FFFF);

        // 5 / 0: flag only, previous divide results held
        run_op("div_5_0", 0, 1, 32'd5, 32'd0, 0);
        check("div_5_0/quot_held", div_lo, 32'hFFFF_FFFD);

        // most-negative / -1, then most-negative squared
        run_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_min_m1/quot_const", div_lo, 32'h8000_0000);
        check("div_min_m1/rem_const", div_hi, 32'h0000_0000);
        run_op("mul_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000, 0);
        check("mul_min_min/hi_const", mult_hi, 32'h4000_0000);
        check("mul_min_min/lo_const", mult_lo, 32'h0000_0000);

        // Both starts together plus a stray start_div mid-operation
        run_op("both_starts", 1, 1, 32'd123, 32'hFFFF_FFD3, 10);

        // A few random signed operations
        for (int i = 0; i < 6; i++) begin
            ra = $urandom() | 32'h1;
            rb = ($urandom() >> ($urandom_range(0, 28))) | 32'h1;
            if (i[0]) rb = ~rb + 1'b1;
            run_op((i % 2 == 0) ? "rand_mul" : "rand_div", (i % 2 == 0), (i % 2 == 1), ra, rb, 0);
        end

        // Reset in the middle of a divide
        start_div = 1'b1;
        a_in = 32'd1000;
        b_in = 32'd7;
        @(posedge clk); #1;
        start_div = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("mid_reset/busy_before", W'(busy), W'(1));
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        m_mhi = '0; m_mlo = '0; m_dhi = '0; m_dlo = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset/busy", W'(busy), W'(0));
        run_op("mul_3_4", 1, 0, 32'd3, 32'd4, 0);
        check("mul_3_4/lo_const", mult_lo, 32'd12);
        check("mul_3_4/div_lo_cleared", div_lo, 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
